// File: rtl/sccpu_mem_responder.sv
// Data-side responder for the single-cycle MIPS CPU: word RAM plus an MMIO block with LED, cycle
// counter, one-shot timer with sticky IRQ and a byte TX FIFO drained by a valid/ready stream.
module sccpu_mem_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wmem,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

    logic [31:0] ram_q [2 ** RAM_AW];
    logic [7:0]  fifo_q [Depth];

    logic [15:0]        led_q, led_d;
    logic [31:0]        cycle_q, cycle_d;
    logic [31:0]        timer_q, timer_d;
    logic               flag_q, flag_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        reg_sel;
    logic              wr_ram, wr_led, wr_timer, wr_status, wr_tx;
    logic              full, empty, pop, push_ok, timer_hit;
    logic [31:0]       status;

    logic unused_addr;
    assign unused_addr = ^{addr[30:RAM_AW+2], addr[1:0]};

    assign ram_idx   = addr[RAM_AW+1:2];
    assign reg_sel   = addr[4:2];
    assign wr_ram    = wmem & ~addr[31];
    assign wr_led    = wmem & addr[31] & (reg_sel == 3'd0);
    assign wr_timer  = wmem & addr[31] & (reg_sel == 3'd2);
    assign wr_status = wmem & addr[31] & (reg_sel == 3'd3);
    assign wr_tx     = wmem & addr[31] & (reg_sel == 3'd4);

    assign full     = (count_q == DepthCnt);
    assign empty    = (count_q == '0);
    assign tx_valid = ~empty;
    assign tx_data  = fifo_q[rptr_q];
    assign pop      = tx_valid & tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = wr_tx & (~full | pop);
    assign led      = led_q;
    assign irq      = flag_q;

    always_comb begin
        led_d     = wr_led ? wdata[15:0] : led_q;
        cycle_d   = cycle_q + 32'd1;
        timer_d   = timer_q;
        timer_hit = 1'b0;
        if (wr_timer) begin
            timer_d = wdata;
        end else if (timer_q != 32'd0) begin
            timer_d   = timer_q - 32'd1;
            timer_hit = (timer_q == 32'd1);
        end

        flag_d = flag_q;
        ovf_d  = ovf_q;
        if (wr_status && wdata[0]) flag_d = 1'b0;
        if (wr_status && wdata[3]) ovf_d = 1'b0;
        if (timer_hit) flag_d = 1'b1;
        if (wr_tx && full && !pop) ovf_d = 1'b1;

        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        if (!push_ok && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q   <= '0;
            cycle_q <= '0;
            timer_q <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            timer_q <= timer_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset, but a write is suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (wr_ram && !reset) ram_q[ram_idx] <= wdata;
        if (push_ok && !reset) fifo_q[wptr_q] <= wdata[7:0];
    end

    always_comb begin
        status = '0;
        status[0] = flag_q;
        status[1] = full;
        status[2] = empty;
        status[3] = ovf_q;
        // Count is FIFO_AW+1 bits wide so a full FIFO reads back as Depth.
        status[8 +: FIFO_AW + 1] = count_q;
    end

    always_comb begin
        rdata = '0;
        if (!addr[31]) begin
            rdata = ram_q[ram_idx];
        end else begin
            case (reg_sel)
                3'd0:    rdata = {16'h0000, led_q};
                3'd1:    rdata = cycle_q;
                3'd2:    rdata = timer_q;
                3'd3:    rdata = status;
                default: rdata = '0;
            endcase
        end
    end

endmodule
